// File: rtl/nrisc_idata_pkg.sv
// Shared types and constants for the NRISC instruction memory and its program loader.
package nrisc_idata_pkg;

   localparam int          NRISC_INSTR_W = 16;
   localparam logic [15:0] NRISC_NOP     = 16'h0000;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DAT_LO,
      DAT_HI,
      DONE
   } ld_state_t;

endpackage

// File: rtl/nrisc_idata_loader.sv
// Byte-stream program loader: parses a little-endian word count followed by that many
// 16-bit words and produces write strobes into the instruction array.
module nrisc_idata_loader
   import nrisc_idata_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [7:0]               data_in,
   input  logic                     valid,
   output logic                     ready,
   output logic                     done,
   output logic                     err,
   output logic                     busy,
   output logic                     we,
   output logic [AW-1:0]            waddr,
   output logic [NRISC_INSTR_W-1:0] wdata
);

   localparam logic [16:0] DEPTH17 = 17'(DEPTH);

   ld_state_t   state;
   logic [15:0] wptr;
   logic [15:0] len;
   logic [7:0]  lo_byte;
   logic        xfer;
   logic        in_range;
   logic [15:0] len_full;
   logic [15:0] wptr_nxt;

   assign ready    = (state == LEN_LO) || (state == LEN_HI) ||
                     (state == DAT_LO) || (state == DAT_HI);
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign xfer     = valid && ready;
   assign in_range = ({1'b0, wptr} < DEPTH17);
   assign len_full = {data_in, len[7:0]};
   assign wptr_nxt = wptr + 16'd1;

   // A restart takes priority over a byte arriving in the same cycle, so no half-built word lands.
   assign we    = (state == DAT_HI) && xfer && !start && in_range;
   assign waddr = wptr[AW-1:0];
   assign wdata = {data_in, lo_byte};

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         wptr    <= '0;
         len     <= '0;
         lo_byte <= '0;
         err     <= 1'b0;
      end else if (start) begin
         state <= LEN_LO;
         wptr  <= '0;
         err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: ;
            LEN_LO: if (xfer) begin
               len[7:0] <= data_in;
               state    <= LEN_HI;
            end
            LEN_HI: if (xfer) begin
               len[15:8] <= data_in;
               state     <= (len_full == 16'd0) ? DONE : DAT_LO;
               if ({1'b0, len_full} > DEPTH17) err <= 1'b1;
            end
            DAT_LO: if (xfer) begin
               lo_byte <= data_in;
               state   <= DAT_HI;
            end
            // Words past the end of the array still count toward LEN but are never written.
            DAT_HI: if (xfer) begin
               wptr  <= wptr_nxt;
               state <= (wptr_nxt == len) ? DONE : DAT_LO;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/nrisc_idata_mem.sv
// NRISC instruction memory: registered fetch port for the core plus the boot program loader.
module nrisc_idata_mem
   import nrisc_idata_pkg::*;
#(
   parameter int TAM   = 16,
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [TAM-1:0]           IDATA_CORE_addr,
   input  logic                     IDATA_clk,
   output logic [NRISC_INSTR_W-1:0] IDATA_CORE_out,
   output logic                     IDATA_busy,
   input  logic                     LOAD_start,
   input  logic [7:0]               LOAD_byte,
   input  logic                     LOAD_valid,
   output logic                     LOAD_ready,
   output logic                     LOAD_done,
   output logic                     LOAD_err
);

   localparam int           AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [TAM:0] DEPTH_L = (TAM + 1)'(DEPTH);

   logic [NRISC_INSTR_W-1:0] mem [DEPTH];
   logic                     we;
   logic [AW-1:0]            waddr;
   logic [NRISC_INSTR_W-1:0] wdata;
   logic                     addr_ok;

   nrisc_idata_loader #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_loader (
      .clk     (clk),
      .rst     (rst),
      .start   (LOAD_start),
      .data_in (LOAD_byte),
      .valid   (LOAD_valid),
      .ready   (LOAD_ready),
      .done    (LOAD_done),
      .err     (LOAD_err),
      .busy    (IDATA_busy),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata)
   );

   assign addr_ok = ({1'b0, IDATA_CORE_addr} < DEPTH_L);

   // Array contents survive reset so a program outlives a core restart.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         IDATA_CORE_out <= NRISC_NOP;
      end else if (IDATA_busy) begin
         IDATA_CORE_out <= NRISC_NOP;
      end else if (IDATA_clk) begin
         IDATA_CORE_out <= addr_ok ? mem[IDATA_CORE_addr[AW-1:0]] : NRISC_NOP;
      end
   end

endmodule
